encoder_move_ctrl: RTL and testbench
====================================

// Module: encoder_move_ctrl
// PURPOSE
//  Closed-loop move sequencer for one quadrature-encoder axis. Synchronises raw A/B inputs
//  and decodes them into signed position steps. Accepts absolute target commands and drives
//  motor enable/direction until the target is reached and settled. Reports timeout faults.
//  Sits between the host/register layer and the motor driver pins.
// PARAMETERS
//  POS_W       32    width of signed position/target registers
//  TIMEOUT_CYC 1000  max clk cycles without a step while in MOVE before FAULT
//  SETTLE_CYC  64    clk cycles motor stays off in SETTLE before completion check
//  TOL         1     allowed |position-target| at completion (unsigned counts)
//  MAX_RETRY   3     SETTLE->MOVE re-entries allowed per command before FAULT
// PORTS
//  clk          in   1      clock
//  rst_n        in   1      asynchronous, active-low reset
//  enc_a        in   1      raw encoder channel A (asynchronous)
//  enc_b        in   1      raw encoder channel B (asynchronous)
//  cmd_valid    in   1      target command valid
//  cmd_ready    out  1      command accepted when valid&ready
//  cmd_target   in   POS_W  signed absolute target position
//  cmd_abort    in   1      stop motion, return to IDLE
//  pos_clear    in   1      zero position counter (ignored unless IDLE)
//  motor_en     out  1      motor drive enable
//  motor_dir    out  1      1 = drive toward increasing count, 0 = decreasing
//  position     out  POS_W  signed current position
//  busy         out  1      state != IDLE
//  done         out  1      one-cycle pulse on successful completion
//  fault        out  1      sticky fault flag, cleared by next accepted command
//  illegal_cnt  out  8      saturating count of illegal A/B transitions
// BEHAVIOUR
//  Reset: all state IDLE; position=0; motor_en=0; motor_dir=0; done=0; fault=0; illegal_cnt=0.
//  Input path: 2-FF synchroniser per channel, then one prev-sample register.
//   Step encoding {prev,curr} in {AB} form:
//   - +1 on 00->10, 10->11, 11->01, 01->00.
//   - -1 on 00->01, 01->11, 11->10, 10->00.
//   - No change: no step.
//   - Both bits change: illegal_cnt+1 (saturates at 255), no step.
//   position updates on the 3rd rising clk edge after an input change; it wraps modulo 2^POS_W.
//  cmd_ready = (state==IDLE) & ~cmd_abort (combinational). Reset value is 1.
//  FSM:
//   IDLE:
//    - On cmd_valid&cmd_ready: latch target; clear fault, retry and timeout counters.
//    - If |target-position|<=TOL: go to DONE. Otherwise go to MOVE.
//   MOVE:
//    - motor_en=1; motor_dir=(target>position), signed compare.
//    - Timeout counter clears on every step and increments otherwise.
//    - position==target -> SETTLE.
//    - Counter reaches TIMEOUT_CYC -> FAULT.
//    - Overshoot past target flips motor_dir the next cycle; no state change.
//   SETTLE:
//    - motor_en=0; counter runs SETTLE_CYC cycles.
//    - At end: if |target-position|<=TOL go to DONE.
//    - Else if retries<MAX_RETRY: retries+1, go to MOVE.
//    - Else go to FAULT.
//   DONE: done=1 for exactly one cycle, then IDLE.
//   FAULT: fault=1, motor_en=0, go to IDLE next cycle (fault stays set).
//  cmd_abort in any non-IDLE state:
//   - motor_en=0 on the next edge; go to IDLE; no done pulse; fault unchanged.
//   - Abort has priority over every other transition in the same cycle.
//  pos_clear in IDLE with a same-cycle command: clear applies first, and the target
//   comparison uses position=0.
//  Steps keep counting in all states, including IDLE. motor_en and motor_dir are registered outputs.
//  Abs-difference uses a POS_W+1-bit signed subtract, so no overflow is possible.
// STRUCTURE
//  Shared package enc_pkg:
//   - state enum (IDLE, MOVE, SETTLE, DONE, FAULT).
//   - step codes STEP_NONE=2'b00, STEP_INC=2'b01, STEP_DEC=2'b10.
//  Sub-module quad_step_decoder:
//   - Contains the synchroniser, prev-sample register and transition table.
//   - Outputs: step[1:0] (registered) and illegal (1-cycle pulse).
//  The top level holds the position accumulator, FSM and timers.
// TESTING
//  1 Reset, then cmd_target=+8 from position 0, encoder model steps +1 every 20 cycles:
//    - motor_en=1, motor_dir=1.
//    - After 8 steps: SETTLE, then done pulse, position=8, busy=0.
//  2 Target=-5: motor_dir=0, position reaches -5, done pulses once.
//  3 Move to +100 with the encoder model stalled:
//    - fault=1 after TIMEOUT_CYC cycles, motor_en=0.
//    - Next accepted command clears fault.
//  4 Model overshoots to target+3 during SETTLE:
//    - Re-enters MOVE with motor_dir=0, completes at target.
//    - 4th overshoot in the same command -> FAULT.
//  5 Assert cmd_abort mid-MOVE:
//    - motor_en=0 the next cycle, IDLE, no done pulse.
//    - A command offered in the same cycle is not accepted.
//  6 Inject A/B 00->11 jumps:
//    - illegal_cnt increments, position unchanged.
//    - 300 jumps saturate illegal_cnt at 255.

Source files
------------

// File: rtl/enc_pkg.sv
// Shared definitions for the encoder move controller.
//   state_e      : move sequencer states
//   STEP_*       : step codes produced by the quadrature decoder
//   decode_step  : {prev,curr} A/B transition table (AB bit order)
package enc_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      MOVE   = 3'd1,
      SETTLE = 3'd2,
      DONE   = 3'd3,
      FAULT  = 3'd4
   } state_e;

   localparam logic [1:0] STEP_NONE = 2'b00;
   localparam logic [1:0] STEP_INC  = 2'b01;
   localparam logic [1:0] STEP_DEC  = 2'b10;

   // Forward sequence is 00 -> 10 -> 11 -> 01 -> 00 in {A,B} form.
   function automatic logic [1:0] decode_step(input logic [1:0] prev_ab,
                                              input logic [1:0] curr_ab);
      logic [1:0] res;
      case ({prev_ab, curr_ab})
         4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: res = STEP_INC;
         4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: res = STEP_DEC;
         default:                                res = STEP_NONE;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/quad_step_decoder.sv
// Quadrature step decoder.
//   clk, rst_n   : clock, asynchronous active-low reset
//   enc_a, enc_b : raw asynchronous encoder channels
//   step[1:0]    : STEP_NONE / STEP_INC / STEP_DEC, valid for one cycle per transition
//   illegal      : one-cycle pulse when both channels changed between samples
// A raw edge lands in sync2_q on the 2nd clock edge; step/illegal are decoded
// purely from registered samples so the consumer updates on the 3rd edge.
module quad_step_decoder
   import enc_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enc_a,
   input  logic       enc_b,
   output logic [1:0] step,
   output logic       illegal
);

   logic [1:0] sync1_q, sync1_d;
   logic [1:0] sync2_q, sync2_d;
   logic [1:0] prev_q,  prev_d;

   always_comb begin
      sync1_d = {enc_a, enc_b};
      sync2_d = sync1_q;
      prev_d  = sync2_q;
      step    = decode_step(prev_q, sync2_q);
      illegal = ((prev_q ^ sync2_q) == 2'b11);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 2'b00;
         sync2_q <= 2'b00;
         prev_q  <= 2'b00;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         prev_q  <= prev_d;
      end
   end

endmodule

// File: rtl/encoder_move_ctrl.sv
// Closed-loop move sequencer for one quadrature-encoder axis.
//   clk, rst_n     : clock, asynchronous active-low reset
//   enc_a, enc_b   : raw encoder channels
//   cmd_valid/cmd_ready/cmd_target : absolute target command
//   cmd_abort      : stop motion and return to IDLE
//   pos_clear      : zero position (IDLE only)
//   motor_en, motor_dir : registered motor driver pins (dir 1 = increasing count)
//   position       : signed current position (wraps)
//   busy, done, fault   : status (done is a one-cycle pulse, fault is sticky)
//   illegal_cnt    : saturating count of illegal A/B transitions
//   dbg_state      : current FSM state encoding (enc_pkg::state_e)
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both high; cmd_ready is high only in IDLE without abort.
module encoder_move_ctrl
   import enc_pkg::*;
#(
   parameter int POS_W       = 32,
   parameter int TIMEOUT_CYC = 1000,
   parameter int SETTLE_CYC  = 64,
   parameter int TOL         = 1,
   parameter int MAX_RETRY   = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enc_a,
   input  logic             enc_b,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [POS_W-1:0] cmd_target,
   input  logic             cmd_abort,
   input  logic             pos_clear,
   output logic             motor_en,
   output logic             motor_dir,
   output logic [POS_W-1:0] position,
   output logic             busy,
   output logic             done,
   output logic             fault,
   output logic [7:0]       illegal_cnt,
   output logic [2:0]       dbg_state
);

   localparam int TMR_MAX = (TIMEOUT_CYC > SETTLE_CYC) ? TIMEOUT_CYC : SETTLE_CYC;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);
   localparam int RTY_W   = $clog2(MAX_RETRY + 2);
   localparam logic [POS_W-1:0] POS_ONE = POS_W'(1);
   localparam logic [POS_W:0]   TOL_V   = (POS_W+1)'(TOL);

   logic [1:0] step;
   logic       illegal;

   quad_step_decoder u_dec (
      .clk     (clk),
      .rst_n   (rst_n),
      .enc_a   (enc_a),
      .enc_b   (enc_b),
      .step    (step),
      .illegal (illegal)
   );

   state_e           state_q, state_d;
   logic [POS_W-1:0] target_q, target_d;
   logic [POS_W-1:0] position_q, position_d;
   logic [POS_W-1:0] pos_base;
   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic [RTY_W-1:0] retry_q, retry_d;
   logic             motor_en_q, motor_en_d;
   logic             motor_dir_q, motor_dir_d;
   logic             done_q, done_d;
   logic             fault_q, fault_d;
   logic [7:0]       illegal_cnt_q, illegal_cnt_d;
   logic             cmd_in_tol, tgt_in_tol;

   // Sign-extended subtract so |tgt-pos| never overflows.
   function automatic logic in_tol(input logic [POS_W-1:0] tgt,
                                   input logic [POS_W-1:0] pos);
      logic [POS_W:0] diff;
      logic [POS_W:0] mag;
      diff = {tgt[POS_W-1], tgt} - {pos[POS_W-1], pos};
      mag  = diff[POS_W] ? -diff : diff;
      return (mag <= TOL_V);
   endfunction

   assign cmd_ready   = (state_q == IDLE) & ~cmd_abort;
   assign busy        = (state_q != IDLE);
   assign motor_en    = motor_en_q;
   assign motor_dir   = motor_dir_q;
   assign position    = position_q;
   assign done        = done_q;
   assign fault       = fault_q;
   assign illegal_cnt = illegal_cnt_q;
   assign dbg_state   = state_q;

   // Position accumulator; a clear in IDLE happens before this cycle's step
   // and before the new-command tolerance check.
   always_comb begin
      pos_base = position_q;
      if (state_q == IDLE && pos_clear) pos_base = '0;
      position_d = pos_base;
      if (step == STEP_INC)      position_d = pos_base + POS_ONE;
      else if (step == STEP_DEC) position_d = pos_base - POS_ONE;

      illegal_cnt_d = illegal_cnt_q;
      if (illegal && illegal_cnt_q != 8'hFF) illegal_cnt_d = illegal_cnt_q + 8'd1;

      cmd_in_tol = in_tol(cmd_target, pos_base);
      tgt_in_tol = in_tol(target_q, position_q);
   end

   always_comb begin
      state_d  = state_q;
      target_d = target_q;
      tmr_d    = tmr_q;
      retry_d  = retry_q;
      fault_d  = fault_q;

      case (state_q)
         IDLE: begin
            if (cmd_valid && cmd_ready) begin
               target_d = cmd_target;
               fault_d  = 1'b0;
               retry_d  = '0;
               tmr_d    = '0;
               state_d  = cmd_in_tol ? DONE : MOVE;
            end
         end
         MOVE: begin
            if (position_q == target_q) begin
               state_d = SETTLE;
               tmr_d   = '0;
            end else if (step != STEP_NONE) begin
               tmr_d = '0;
            end else begin
               tmr_d = tmr_q + TMR_W'(1);
               if (tmr_d == TMR_W'(TIMEOUT_CYC)) state_d = FAULT;
            end
         end
         SETTLE: begin
            if (tmr_q == TMR_W'(SETTLE_CYC - 1)) begin
               tmr_d = '0;
               if (tgt_in_tol) begin
                  state_d = DONE;
               end else if (retry_q < RTY_W'(MAX_RETRY)) begin
                  retry_d = retry_q + RTY_W'(1);
                  state_d = MOVE;
               end else begin
                  state_d = FAULT;
               end
            end else begin
               tmr_d = tmr_q + TMR_W'(1);
            end
         end
         DONE:    state_d = IDLE;
         FAULT:   state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Abort outranks every other transition and leaves fault untouched.
      if (cmd_abort && state_q != IDLE) begin
         state_d = IDLE;
         fault_d = fault_q;
      end

      if (state_d == FAULT) fault_d = 1'b1;

      // Outputs are registered from the next state; direction tracks the
      // post-step position so an overshoot reverses the motor one cycle later.
      motor_en_d  = (state_d == MOVE);
      motor_dir_d = motor_dir_q;
      if (state_d == MOVE) motor_dir_d = ($signed(target_d) > $signed(position_d));
      done_d      = (state_d == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         target_q      <= '0;
         position_q    <= '0;
         tmr_q         <= '0;
         retry_q       <= '0;
         motor_en_q    <= 1'b0;
         motor_dir_q   <= 1'b0;
         done_q        <= 1'b0;
         fault_q       <= 1'b0;
         illegal_cnt_q <= 8'd0;
      end else begin
         state_q       <= state_d;
         target_q      <= target_d;
         position_q    <= position_d;
         tmr_q         <= tmr_d;
         retry_q       <= retry_d;
         motor_en_q    <= motor_en_d;
         motor_dir_q   <= motor_dir_d;
         done_q        <= done_d;
         fault_q       <= fault_d;
         illegal_cnt_q <= illegal_cnt_d;
      end
   end

endmodule

// File: tb/tb_encoder_move_ctrl.sv
// Bench for encoder_move_ctrl: directed moves driven through a quadrature
// encoder model; done/fault events are matched against an expected queue.
module tb_encoder_move_ctrl;

   localparam int POS_W = 32;
   localparam int EW    = 34;   // {kind[1:0], position[31:0]}

   logic             clk = 1'b0;
   logic             rst_n;
   logic             enc_a, enc_b;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [POS_W-1:0] cmd_target;
   logic             cmd_abort;
   logic             pos_clear;
   logic             motor_en, motor_dir;
   logic [POS_W-1:0] position;
   logic             busy, done, fault;
   logic [7:0]       illegal_cnt;
   logic [2:0]       dbg_state;

   encoder_move_ctrl dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .enc_a       (enc_a),
      .enc_b       (enc_b),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_target  (cmd_target),
      .cmd_abort   (cmd_abort),
      .pos_clear   (pos_clear),
      .motor_en    (motor_en),
      .motor_dir   (motor_dir),
      .position    (position),
      .busy        (busy),
      .done        (done),
      .fault       (fault),
      .illegal_cnt (illegal_cnt),
      .dbg_state   (dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard state ----------------
   int checks   = 0;
   int failures = 0;
   logic [EW-1:0] exp_q[$];
   logic [EW-1:0] mon_act, mon_exp;
   logic          fault_prev = 1'b0;
   int            phase = 0;

   localparam logic [1:0] EV_DONE  = 2'd1;
   localparam logic [1:0] EV_FAULT = 2'd2;

   function automatic logic [EW-1:0] ev(input logic [1:0] kind, input logic [31:0] pos);
      return {kind, pos};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Monitor: every done pulse or fault rise must match the queue head.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (done === 1'b1 || (fault === 1'b1 && fault_prev === 1'b0)) begin
            mon_act = ev((done === 1'b1) ? EV_DONE : EV_FAULT, position);
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL monitor_unexpected actual=%0h required=none", mon_act);
            end else begin
               mon_exp = exp_q.pop_front();
               if (mon_act !== mon_exp) begin
                  failures++;
                  $display("FAIL monitor_event actual=%0h required=%0h", mon_act, mon_exp);
               end
            end
         end
         fault_prev = fault;
      end
   end

   // ---------------- driver tasks ----------------
   function automatic logic [1:0] gray(input int p);
      logic [1:0] g;
      case (p & 3)
         0:       g = 2'b00;
         1:       g = 2'b10;
         2:       g = 2'b11;
         default: g = 2'b01;
      endcase
      return g;
   endfunction

   task automatic enc_move(input int dir, input int n, input int gap);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         phase = phase + dir;
         {enc_a, enc_b} = gray(phase);
         repeat (gap - 1) @(negedge clk);
      end
   endtask

   task automatic send_cmd(input logic [31:0] tgt, input logic clr);
      @(negedge clk);
      cmd_valid  = 1'b1;
      cmd_target = tgt;
      pos_clear  = clr;
      #1;
      check("cmd_ready_offer", 32'(cmd_ready), 32'd1);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      pos_clear = 1'b0;
   endtask

   task automatic wait_en(input logic val, input int budget, input string name);
      int n = 0;
      while (motor_en !== val && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(name, 32'(motor_en), 32'(val));
   endtask

   task automatic wait_idle(input int budget, input string name);
      int n = 0;
      while (busy !== 1'b0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(name, 32'(busy), 32'd0);
   endtask

   task automatic wait_fault(input int budget, input string name);
      int n = 0;
      while (fault !== 1'b1 && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(name, 32'(fault), 32'd1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst_n      = 1'b0;
      enc_a      = 1'b0;
      enc_b      = 1'b0;
      cmd_valid  = 1'b0;
      cmd_target = '0;
      cmd_abort  = 1'b0;
      pos_clear  = 1'b0;
      #12;
      check("rst_position",  position,           32'd0);
      check("rst_motor_en",  32'(motor_en),      32'd0);
      check("rst_motor_dir", 32'(motor_dir),     32'd0);
      check("rst_done",      32'(done),          32'd0);
      check("rst_fault",     32'(fault),         32'd0);
      check("rst_illegal",   32'(illegal_cnt),   32'd0);
      check("rst_busy",      32'(busy),          32'd0);
      check("rst_cmd_ready", 32'(cmd_ready),     32'd1);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // 1: move 0 -> +8
      exp_q.push_back(ev(EV_DONE, 32'd8));
      send_cmd(32'd8, 1'b0);
      @(negedge clk);
      check("t1_motor_en",  32'(motor_en),  32'd1);
      check("t1_motor_dir", 32'(motor_dir), 32'd1);
      check("t1_busy",      32'(busy),      32'd1);
      enc_move(1, 8, 20);
      wait_idle(200, "t1_idle");
      check("t1_position", position, 32'd8);

      // 2: move +8 -> -5
      exp_q.push_back(ev(EV_DONE, 32'hFFFF_FFFB));
      send_cmd(32'hFFFF_FFFB, 1'b0);
      @(negedge clk);
      check("t2_motor_en",  32'(motor_en),  32'd1);
      check("t2_motor_dir", 32'(motor_dir), 32'd0);
      enc_move(-1, 13, 20);
      wait_idle(200, "t2_idle");
      check("t2_position", position, 32'hFFFF_FFFB);

      // 3: stalled move times out; next command clears the fault
      exp_q.push_back(ev(EV_FAULT, 32'hFFFF_FFFB));
      send_cmd(32'd100, 1'b0);
      @(negedge clk);
      check("t3_motor_dir", 32'(motor_dir), 32'd1);
      wait_fault(1200, "t3_fault");
      check("t3_motor_en_off", 32'(motor_en), 32'd0);
      wait_idle(10, "t3_idle");
      check("t3_fault_sticky", 32'(fault), 32'd1);
      exp_q.push_back(ev(EV_DONE, 32'hFFFF_FFFB));
      send_cmd(32'hFFFF_FFFB, 1'b0);
      #1;
      check("t3_fault_cleared", 32'(fault), 32'd0);
      wait_idle(10, "t3_idle2");

      // 4a: one overshoot in SETTLE, retry back to target
      exp_q.push_back(ev(EV_DONE, 32'd0));
      send_cmd(32'd0, 1'b0);
      enc_move(1, 5, 10);
      wait_en(1'b0, 50, "t4a_settle");
      enc_move(1, 3, 5);
      wait_en(1'b1, 120, "t4a_retry_en");
      check("t4a_retry_dir", 32'(motor_dir), 32'd0);
      enc_move(-1, 3, 20);
      wait_idle(200, "t4a_idle");
      check("t4a_position", position, 32'd0);

      // 4b: four overshoots in one command -> FAULT
      exp_q.push_back(ev(EV_FAULT, 32'd7));
      send_cmd(32'd4, 1'b0);
      enc_move(1, 4, 10);
      for (int k = 0; k < 4; k++) begin
         wait_en(1'b0, 50, "t4b_settle");
         enc_move(1, 3, 5);
         if (k < 3) begin
            wait_en(1'b1, 120, "t4b_retry_en");
            check("t4b_retry_dir", 32'(motor_dir), 32'd0);
            enc_move(-1, 3, 10);
         end
      end
      wait_fault(120, "t4b_fault");
      check("t4b_motor_en_off", 32'(motor_en), 32'd0);
      wait_idle(10, "t4b_idle");

      // 5: abort mid-MOVE with a competing command
      send_cmd(32'd50, 1'b0);
      repeat (5) @(negedge clk);
      check("t5_fault_cleared", 32'(fault),    32'd0);
      check("t5_motor_en",      32'(motor_en), 32'd1);
      cmd_abort  = 1'b1;
      cmd_valid  = 1'b1;
      cmd_target = 32'd20;
      #1;
      check("t5_ready_during_abort", 32'(cmd_ready), 32'd0);
      @(posedge clk);
      #1;
      cmd_abort = 1'b0;
      cmd_valid = 1'b0;
      @(negedge clk);
      check("t5_motor_en_off", 32'(motor_en), 32'd0);
      check("t5_busy",         32'(busy),     32'd0);
      repeat (30) @(negedge clk);
      check("t5_not_accepted", 32'(busy),     32'd0);
      check("t5_position",     position,      32'd7);
      cmd_abort = 1'b1;
      #1;
      check("t5_idle_abort_ready", 32'(cmd_ready), 32'd0);
      cmd_abort = 1'b0;

      // pos_clear with same-cycle command: target 1 is within TOL of 0
      exp_q.push_back(ev(EV_DONE, 32'd0));
      send_cmd(32'd1, 1'b1);
      wait_idle(10, "clr_idle");
      check("clr_position", position, 32'd0);

      // Step latency in IDLE: position moves on the 3rd edge
      @(negedge clk);
      phase = phase + 1;
      {enc_a, enc_b} = gray(phase);
      @(negedge clk);
      @(negedge clk);
      check("lat_edge2", position, 32'd0);
      @(negedge clk);
      check("lat_edge3", position, 32'd1);

      // 6: illegal double-bit jumps
      @(negedge clk);
      phase = phase + 2;
      {enc_a, enc_b} = gray(phase);
      repeat (4) @(negedge clk);
      check("t6_illegal_one", 32'(illegal_cnt), 32'd1);
      check("t6_position",    position,         32'd1);
      for (int j = 0; j < 299; j++) begin
         @(negedge clk);
         phase = phase + 2;
         {enc_a, enc_b} = gray(phase);
         repeat (3) @(negedge clk);
      end
      repeat (4) @(negedge clk);
      check("t6_illegal_sat", 32'(illegal_cnt), 32'd255);
      check("t6_position_2",  position,         32'd1);

      repeat (10) @(negedge clk);
      check("exp_q_drained", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
